// File: rtl/alarm_pattern_player_pkg.sv
// Shared definitions for the alarm pattern player: player state encoding and
// the millisecond prescaler divide derived from the system clock frequency.
package alarm_pattern_player_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_e;

   localparam int MS_PER_S = 1000;

   // MS_DIV: clock cycles per millisecond tick.
   function automatic int ms_div(input int clk_hz);
      return clk_hz / MS_PER_S;
   endfunction

endpackage

// File: rtl/alarm_pattern_player_tone_gen.sv
// Phase-accumulator square-wave generator: the output toggles each time the
// accumulator crosses CLK_HZ, giving a square wave of frequency hz.
module tone_gen #(
   parameter int CLK_HZ = 100_000_000,
   parameter int HZ_W   = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            clr,
   input  logic [HZ_W-1:0] hz,
   output logic            wave
);

   localparam int ACC_W = $clog2(CLK_HZ) + 2;
   localparam int SUM_W = ACC_W + 1;
   localparam logic [SUM_W-1:0] LIMIT = SUM_W'(CLK_HZ);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             wave_q, wave_d;
   logic [SUM_W-1:0] sum;

   always_comb begin
      acc_d  = acc_q;
      wave_d = wave_q;
      // Adding 2*hz per cycle makes each half-period last CLK_HZ/(2*hz) cycles.
      sum    = {1'b0, acc_q} + SUM_W'({hz, 1'b0});
      if (clr) begin
         acc_d  = '0;
         wave_d = 1'b0;
      end else if (en) begin
         if (sum >= LIMIT) begin
            acc_d  = ACC_W'(sum - LIMIT);
            wave_d = ~wave_q;
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         wave_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         wave_q <= wave_d;
      end
   end

   assign wave = wave_q;

endmodule

// File: rtl/alarm_pattern_player.sv
// Alarm beep pattern player: latches a beep pattern on set and drives the
// buzzer through tone_gen with ms-accurate on/off phases and repeat counting.
module alarm_pattern_player
   import alarm_pattern_player_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int HZ_W   = 12,
   parameter int MS_W   = 12,
   parameter int REP_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic             stop,
   input  logic             mode,
   input  logic [HZ_W-1:0]  hz_a,
   input  logic [HZ_W-1:0]  hz_b,
   input  logic [MS_W-1:0]  on_ms,
   input  logic [MS_W-1:0]  off_ms,
   input  logic [REP_W-1:0] repeats,
   output logic             buzzer,
   output logic             busy,
   output logic             done
);

   localparam int MS_DIV = ms_div(CLK_HZ);
   localparam int PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

   state_e           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [MS_W-1:0]  ms_q, ms_d;
   logic [REP_W-1:0] idx_q, idx_d;
   logic             done_q, done_d;
   logic             mode_q, mode_d;
   logic [HZ_W-1:0]  hz_a_q, hz_a_d, hz_b_q, hz_b_d;
   logic [MS_W-1:0]  on_q, on_d, off_q, off_d;
   logic [REP_W-1:0] rep_q, rep_d;

   logic             tick;
   logic             last_beep;
   logic [MS_W-1:0]  on_len;
   logic             tone_clr;
   logic [HZ_W-1:0]  hz_sel;

   assign tick      = (pre_q == PRE_W'(MS_DIV - 1));
   assign on_len    = (on_q == '0) ? MS_W'(1) : on_q;
   assign last_beep = (rep_q != '0) && (idx_q == rep_q - REP_W'(1));
   assign hz_sel    = (!idx_q[0] || !mode_q) ? hz_a_q : hz_b_q;

   always_comb begin
      state_d  = state_q;
      pre_d    = (state_q == ST_IDLE) ? '0 : (tick ? '0 : pre_q + PRE_W'(1));
      ms_d     = tick ? ms_q + MS_W'(1) : ms_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      mode_d   = mode_q;
      hz_a_d   = hz_a_q;
      hz_b_d   = hz_b_q;
      on_d     = on_q;
      off_d    = off_q;
      rep_d    = rep_q;
      tone_clr = (state_q != ST_ON);

      // Every phase change restarts the ms timebase and the tone phase.
      case (state_q)
         ST_ON: begin
            if (tick && (ms_q == on_len - MS_W'(1))) begin
               pre_d    = '0;
               ms_d     = '0;
               tone_clr = 1'b1;
               if (last_beep) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else if (off_q == '0) begin
                  idx_d   = idx_q + REP_W'(1);
                  state_d = ST_ON;
               end else begin
                  state_d = ST_OFF;
               end
            end
         end
         ST_OFF: begin
            if (tick && (ms_q == off_q - MS_W'(1))) begin
               pre_d    = '0;
               ms_d     = '0;
               tone_clr = 1'b1;
               idx_d    = idx_q + REP_W'(1);
               state_d  = ST_ON;
            end
         end
         default: begin
            ms_d = '0;
         end
      endcase

      if (set) begin
         mode_d   = mode;
         hz_a_d   = hz_a;
         hz_b_d   = hz_b;
         on_d     = on_ms;
         off_d    = off_ms;
         rep_d    = repeats;
         idx_d    = '0;
         pre_d    = '0;
         ms_d     = '0;
         tone_clr = 1'b1;
         done_d   = 1'b0;
         state_d  = ST_ON;
      end

      if (stop) begin
         pre_d    = '0;
         ms_d     = '0;
         tone_clr = 1'b1;
         done_d   = 1'b0;
         state_d  = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         ms_q    <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         mode_q  <= 1'b0;
         hz_a_q  <= '0;
         hz_b_q  <= '0;
         on_q    <= '0;
         off_q   <= '0;
         rep_q   <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         ms_q    <= ms_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         mode_q  <= mode_d;
         hz_a_q  <= hz_a_d;
         hz_b_q  <= hz_b_d;
         on_q    <= on_d;
         off_q   <= off_d;
         rep_q   <= rep_d;
      end
   end

   tone_gen #(
      .CLK_HZ (CLK_HZ),
      .HZ_W   (HZ_W)
   ) u_tone (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == ST_ON),
      .clr  (tone_clr),
      .hz   (hz_sel),
      .wave (buzzer)
   );

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_alarm_pattern_player.sv
// Directed self-checking bench for alarm_pattern_player at CLK_HZ=100_000
// (100 cycles per ms); outputs are sampled 1 time unit after each rising edge.
module tb_alarm_pattern_player;

   localparam int CLK_HZ = 100_000;
   localparam int HZ_W   = 12;
   localparam int MS_W   = 12;
   localparam int REP_W  = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             set;
   logic             stop;
   logic             mode;
   logic [HZ_W-1:0]  hz_a;
   logic [HZ_W-1:0]  hz_b;
   logic [MS_W-1:0]  on_ms;
   logic [MS_W-1:0]  off_ms;
   logic [REP_W-1:0] repeats;
   logic             buzzer;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alarm_pattern_player #(
      .CLK_HZ (CLK_HZ),
      .HZ_W   (HZ_W),
      .MS_W   (MS_W),
      .REP_W  (REP_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .set     (set),
      .stop    (stop),
      .mode    (mode),
      .hz_a    (hz_a),
      .hz_b    (hz_b),
      .on_ms   (on_ms),
      .off_ms  (off_ms),
      .repeats (repeats),
      .buzzer  (buzzer),
      .busy    (busy),
      .done    (done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulses set for one clock; returns 1 time unit after the ON-entry edge.
   task automatic start(input logic m, input int ha, input int hb,
                        input int onm, input int offm, input int rep);
      mode    = m;
      hz_a    = ha[HZ_W-1:0];
      hz_b    = hb[HZ_W-1:0];
      on_ms   = onm[MS_W-1:0];
      off_ms  = offm[MS_W-1:0];
      repeats = rep[REP_W-1:0];
      set     = 1'b1;
      step();
      set     = 1'b0;
      hz_a    = '0;
      hz_b    = '0;
      on_ms   = '0;
      off_ms  = '0;
      repeats = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; set = 1'b0; stop = 1'b0; mode = 1'b0;
      hz_a = '0; hz_b = '0; on_ms = '0; off_ms = '0; repeats = '0;
      step();
      step();
      n_checks++;
      if ({buzzer, busy, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs: {buzzer,busy,done} got %b expected 000", {buzzer, busy, done});
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if ({buzzer, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle k=%0d: {buzzer,busy,done} got %b expected 000", k, {buzzer, busy, done});
         end
      end
   endtask

   // 1 kHz, 3 ms on, 2 ms off, 2 beeps: done 800 cycles after ON entry.
   task automatic test_single_tone();
      logic [2:0] e;
      start(1'b0, 1000, 0, 3, 2, 2);
      n_checks++;
      if ({buzzer, busy, done} !== 3'b010) begin
         n_fail++;
         $display("FAIL single_entry: {buzzer,busy,done} got %b expected 010", {buzzer, busy, done});
      end
      for (int k = 1; k <= 801; k++) begin
         step();
         if (k < 300)      e[2] = ((k / 50) % 2) == 1;
         else if (k < 500) e[2] = 1'b0;
         else if (k < 800) e[2] = (((k - 500) / 50) % 2) == 1;
         else              e[2] = 1'b0;
         e[1] = (k < 800);
         e[0] = (k == 800);
         n_checks++;
         if ({buzzer, busy, done} !== e) begin
            n_fail++;
            $display("FAIL single_tone k=%0d: {buzzer,busy,done} got %b expected %b", k, {buzzer, busy, done}, e);
         end
      end
   endtask

   // Alternating 1000/500 Hz, 3 ms beeps, no gap.
   task automatic test_alternate();
      logic [2:0] e;
      start(1'b1, 1000, 500, 3, 0, 2);
      for (int k = 1; k <= 601; k++) begin
         step();
         if (k < 300)      e[2] = ((k / 50) % 2) == 1;
         else if (k < 600) e[2] = (((k - 300) / 100) % 2) == 1;
         else              e[2] = 1'b0;
         e[1] = (k < 600);
         e[0] = (k == 600);
         n_checks++;
         if ({buzzer, busy, done} !== e) begin
            n_fail++;
            $display("FAIL alternate k=%0d: {buzzer,busy,done} got %b expected %b", k, {buzzer, busy, done}, e);
         end
      end
   endtask

   // Continuous mode for 21+ beeps, then stop mid-ON.
   task automatic test_continuous_stop();
      logic [2:0] e;
      int m;
      start(1'b0, 1000, 0, 1, 1, 0);
      for (int k = 1; k <= 4260; k++) begin
         step();
         m = k % 200;
         e[2] = (m < 100) && (((m / 50) % 2) == 1);
         e[1] = 1'b1;
         e[0] = 1'b0;
         n_checks++;
         if ({buzzer, busy, done} !== e) begin
            n_fail++;
            $display("FAIL continuous k=%0d: {buzzer,busy,done} got %b expected %b", k, {buzzer, busy, done}, e);
         end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_checks++;
      if ({buzzer, busy, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL stop_next: {buzzer,busy,done} got %b expected 000", {buzzer, busy, done});
      end
      for (int k = 0; k < 5; k++) begin
         step();
         n_checks++;
         if ({buzzer, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL stop_idle k=%0d: {buzzer,busy,done} got %b expected 000", k, {buzzer, busy, done});
         end
      end
   endtask

   // Retrigger during OFF restarts at beep 0 with the new 500 Hz, 2 ms config.
   task automatic test_retrigger();
      logic [2:0] e;
      start(1'b0, 1000, 0, 3, 2, 3);
      for (int k = 1; k <= 350; k++) begin
         step();
         e = {(k < 300) && (((k / 50) % 2) == 1), 1'b1, 1'b0};
         n_checks++;
         if ({buzzer, busy, done} !== e) begin
            n_fail++;
            $display("FAIL retrig_first k=%0d: {buzzer,busy,done} got %b expected %b", k, {buzzer, busy, done}, e);
         end
      end
      start(1'b0, 500, 0, 2, 1, 1);
      for (int k = 1; k <= 201; k++) begin
         step();
         e[2] = (k < 200) && (((k / 100) % 2) == 1);
         e[1] = (k < 200);
         e[0] = (k == 200);
         n_checks++;
         if ({buzzer, busy, done} !== e) begin
            n_fail++;
            $display("FAIL retrig_new k=%0d: {buzzer,busy,done} got %b expected %b", k, {buzzer, busy, done}, e);
         end
      end
   endtask

   // set+stop together while IDLE stays IDLE; hz_a=0 keeps timing but stays silent.
   task automatic test_set_stop_and_silent();
      logic [2:0] e;
      mode = 1'b0; hz_a = 12'd1000; on_ms = 12'd2; off_ms = 12'd1; repeats = 4'd1;
      set = 1'b1; stop = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         set = 1'b0; stop = 1'b0;
         n_checks++;
         if ({buzzer, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL set_stop k=%0d: {buzzer,busy,done} got %b expected 000", k, {buzzer, busy, done});
         end
      end
      start(1'b0, 0, 0, 2, 1, 2);
      for (int k = 1; k <= 501; k++) begin
         step();
         e = {1'b0, (k < 500), (k == 500)};
         n_checks++;
         if ({buzzer, busy, done} !== e) begin
            n_fail++;
            $display("FAIL silent k=%0d: {buzzer,busy,done} got %b expected %b", k, {buzzer, busy, done}, e);
         end
      end
   endtask

   // Asynchronous reset mid-ON clears outputs between clock edges.
   task automatic test_async_reset();
      logic [2:0] e;
      start(1'b0, 1000, 0, 3, 0, 1);
      for (int k = 1; k <= 75; k++) step();
      n_checks++;
      if ({buzzer, busy, done} !== 3'b110) begin
         n_fail++;
         $display("FAIL areset_pre: {buzzer,busy,done} got %b expected 110", {buzzer, busy, done});
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({buzzer, busy, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL areset_immediate: {buzzer,busy,done} got %b expected 000", {buzzer, busy, done});
      end
      step();
      step();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         n_checks++;
         if ({buzzer, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL areset_idle k=%0d: {buzzer,busy,done} got %b expected 000", k, {buzzer, busy, done});
         end
      end
      start(1'b0, 1000, 0, 3, 0, 1);
      for (int k = 1; k <= 60; k++) begin
         step();
         e = {((k / 50) % 2) == 1, 1'b1, 1'b0};
         n_checks++;
         if ({buzzer, busy, done} !== e) begin
            n_fail++;
            $display("FAIL areset_restart k=%0d: {buzzer,busy,done} got %b expected %b", k, {buzzer, busy, done}, e);
         end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_tone();
      test_alternate();
      test_continuous_stop();
      test_retrigger();
      test_set_stop_and_silent();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
